// File: rtl/mm_engine.sv
// Sequential signed 8x8 matrix multiplier: C = A x B, one MAC per clock.
// A/B/C live in internal element memories; C is read back through a registered port.
module mm_engine #(
   parameter int MAT_DIM = 8,
   parameter int IN_W    = 8,
   parameter int OUT_W   = 19
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 load_mem,
   input  logic                                 wenA,
   input  logic                                 wenB,
   input  logic                                 wenC,
   input  logic [$clog2(MAT_DIM*MAT_DIM)-1:0]   addrA,
   input  logic [$clog2(MAT_DIM*MAT_DIM)-1:0]   addrB,
   input  logic [$clog2(MAT_DIM*MAT_DIM)-1:0]   addrC,
   input  logic [IN_W-1:0]                      wdA,
   input  logic [IN_W-1:0]                      wdB,
   input  logic                                 start,
   output logic                                 done,
   output logic [OUT_W-1:0]                     rdC
);
   localparam int MAT_SIZE = MAT_DIM * MAT_DIM;
   localparam int IW       = $clog2(MAT_DIM);
   localparam int PW       = 2 * IN_W;
   localparam logic [IW-1:0] IDX_MAX = IW'(MAT_DIM - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]              r_state;
   logic [IW-1:0]           r_i, r_j, r_k;
   logic signed [OUT_W-1:0] r_acc;
   logic                    r_done;
   logic [OUT_W-1:0]        r_rd;

   logic signed [IN_W-1:0]  r_memA [MAT_SIZE];
   logic signed [IN_W-1:0]  r_memB [MAT_SIZE];
   logic signed [OUT_W-1:0] r_memC [MAT_SIZE];

   logic                    w_run, w_mem_wr, w_go, w_last_k, w_last;
   logic signed [PW-1:0]    w_a, w_b, w_prod;
   logic signed [OUT_W-1:0] w_prod_x, w_sum;

   assign w_run    = (r_state == S_RUN);
   assign w_mem_wr = !w_run && load_mem;
   assign w_go     = !w_run && !load_mem && start;
   assign w_last_k = (r_k == IDX_MAX);
   assign w_last   = w_last_k && (r_i == IDX_MAX) && (r_j == IDX_MAX);

   // Row-major addressing reduces to bit concatenation of the loop indices.
   assign w_a      = PW'(r_memA[{r_i, r_k}]);
   assign w_b      = PW'(r_memB[{r_k, r_j}]);
   assign w_prod   = w_a * w_b;
   assign w_prod_x = {{(OUT_W-PW){w_prod[PW-1]}}, w_prod};
   assign w_sum    = r_acc + w_prod_x;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_i     <= '0;
         r_j     <= '0;
         r_k     <= '0;
         r_acc   <= '0;
         r_done  <= 1'b0;
      end else if (w_run) begin
         if (w_last_k) begin
            r_acc <= '0;
            r_k   <= '0;
            r_j   <= (r_j == IDX_MAX) ? '0 : r_j + 1'b1;
            if (r_j == IDX_MAX)
               r_i <= (r_i == IDX_MAX) ? '0 : r_i + 1'b1;
            if (w_last) begin
               r_state <= S_DONE;
               r_done  <= 1'b1;
            end
         end else begin
            r_acc <= w_sum;
            r_k   <= r_k + 1'b1;
         end
      end else if (w_go) begin
         r_state <= S_RUN;
         r_i     <= '0;
         r_j     <= '0;
         r_k     <= '0;
         r_acc   <= '0;
         r_done  <= 1'b0;
      end
   end

   // Element memories are deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_mem_wr) begin
         if (wenA) r_memA[addrA] <= wdA;
         if (wenB) r_memB[addrB] <= wdB;
         if (wenC) r_memC[addrC] <= '0;
      end
      if (w_run && w_last_k)
         r_memC[{r_i, r_j}] <= w_sum;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_rd <= '0;
      else       r_rd <= r_memC[addrC];
   end

   assign done = r_done;
   assign rdC  = r_rd;
endmodule

// File: tb/tb_mm_engine.sv
// Randomized bench for mm_engine: a matrix-level reference model predicts done and
// rdC each cycle; a few literal expectations pin the model to hand-computed values.
module tb_mm_engine;
   logic        clk = 1'b0, reset = 1'b1;
   logic        load_mem = 1'b0, wenA = 1'b0, wenB = 1'b0, wenC = 1'b0, start = 1'b0;
   logic [5:0]  addrA = '0, addrB = '0, addrC = '0;
   logic [7:0]  wdA = '0, wdB = '0;
   logic        done;
   logic [18:0] rdC;

   int vectors = 0, miscompares = 0;

   mm_engine dut (
      .clk(clk), .reset(reset), .load_mem(load_mem),
      .wenA(wenA), .wenB(wenB), .wenC(wenC),
      .addrA(addrA), .addrB(addrB), .addrC(addrC),
      .wdA(wdA), .wdB(wdB), .start(start), .done(done), .rdC(rdC)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic signed [31:0] act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: matrices as int arrays, result computed whole when the run ends.
   int mA[64], mB[64], mC[64];
   bit cval[64];
   bit m_busy = 0, exp_done = 0, exp_rd_v = 0, chk_en = 0;
   int m_cnt = 0, exp_rd = 0;

   function automatic void matmul();
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            int s = 0;
            for (int k = 0; k < 8; k++) s += mA[i*8+k] * mB[k*8+j];
            mC[i*8+j] = s;
            cval[i*8+j] = 1;
         end
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_busy = 0; m_cnt = 0; exp_done = 0; exp_rd = 0; exp_rd_v = 1;
      end else begin
         exp_rd   = mC[addrC];
         exp_rd_v = cval[addrC];
         if (m_busy) begin
            m_cnt++;
            if (m_cnt == 512) begin matmul(); m_busy = 0; exp_done = 1; end
         end else if (load_mem) begin
            if (wenA) mA[addrA] = int'($signed(wdA));
            if (wenB) mB[addrB] = int'($signed(wdB));
            if (wenC) begin mC[addrC] = 0; cval[addrC] = 1; end
         end else if (start) begin
            m_busy = 1; m_cnt = 0; exp_done = 0;
            for (int n = 0; n < 64; n++) cval[n] = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("done", done, int'(exp_done));
         if (exp_rd_v) check("rdC", $signed(rdC), exp_rd);
      end
   end

   int ta[64], tbm[64];

   function automatic int rnd8();
      logic [7:0] v = 8'($urandom);
      return int'($signed(v));
   endfunction

   task automatic load_ab();
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         load_mem = 1; wenA = 1; wenB = 1;
         addrA = 6'(n); addrB = 6'(n); wdA = 8'(ta[n]); wdB = 8'(tbm[n]);
      end
      @(negedge clk);
      load_mem = 0; wenA = 0; wenB = 0;
   endtask

   task automatic run(input int interfere_at, input int reset_at);
      int lat = -1;
      bit aborted = 0;
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
      check("done_clr", done, 0);
      for (int c = 0; c < 600; c++) begin
         if (done === 1'b1) begin lat = c; break; end
         if (c == interfere_at) begin start = 1; load_mem = 1; wenA = 1; addrA = 6'd0; wdA = 8'd55; end
         if (c == interfere_at + 1) begin start = 0; load_mem = 0; wenA = 0; end
         if (c == reset_at) begin
            #2 reset = 1;
            #1 check("rst_done", done, 0);
            check("rst_rdC", $signed(rdC), 0);
            @(negedge clk); reset = 0;
            aborted = 1;
            break;
         end
         @(negedge clk);
      end
      if (!aborted) check("latency", lat, 512);
   endtask

   // mode 0: model only; 1: literal n-32; 2: literal constant val
   task automatic read_all(input int mode, input int val);
      for (int n = 0; n <= 64; n++) begin
         @(negedge clk);
         if (n > 0 && mode == 1) check("rd_ident", $signed(rdC), n - 1 - 32);
         if (n > 0 && mode == 2) check("rd_const", $signed(rdC), val);
         if (n < 64) addrC = 6'(n);
      end
   endtask

   task automatic rand_mats();
      for (int n = 0; n < 64; n++) begin ta[n] = rnd8(); tbm[n] = rnd8(); end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_en = 1;
      check("reset_done", done, 0);
      check("reset_rdC", $signed(rdC), 0);
      reset = 0;

      for (int n = 0; n < 64; n++) begin ta[n] = (n / 8 == n % 8) ? 1 : 0; tbm[n] = n - 32; end
      load_ab(); run(-1, -1); read_all(1, 0);
      check("model_pin", mC[63], 31);

      for (int n = 0; n < 64; n++) begin ta[n] = -128; tbm[n] = -128; end
      load_ab(); run(-1, -1); read_all(2, 131072);

      for (int n = 0; n < 64; n++) begin ta[n] = 127; tbm[n] = -128; end
      load_ab(); run(-1, -1); read_all(2, -130048);
      for (int n = 0; n < 64; n++) ta[n] = 0;
      load_ab(); run(-1, -1); read_all(2, 0);

      rand_mats(); load_ab(); run(100, -1); read_all(0, 0);

      rand_mats(); load_ab(); run(-1, 200);
      rand_mats(); load_ab(); run(-1, -1); read_all(0, 0);

      @(negedge clk); load_mem = 1; wenC = 1; addrC = 6'd9;
      @(negedge clk); load_mem = 0; wenC = 0;
      @(negedge clk); check("clr9", $signed(rdC), 0);
      load_mem = 1; start = 1;
      @(negedge clk); load_mem = 0; start = 0;
      repeat (5) @(negedge clk);
      check("no_start", done, 1);
      check("clr9_hold", $signed(rdC), 0);

      repeat (2) begin rand_mats(); load_ab(); run(-1, -1); read_all(0, 0); end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
